// File: rtl/correlator_pkg.sv
// Shared types and helpers for the correlator readout scheduler.
// READOUT_CHECKSUM_EN adds the trailing checksum state.
package correlator_pkg;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StSeq,
    StData
`ifdef READOUT_CHECKSUM_EN
    ,
    StCsum
`endif
  } state_e;

  function automatic int unsigned BYTES_PER_FRAME(input int unsigned num_corr,
                                                  input int unsigned res);
    return num_corr * res / 8;
  endfunction

endpackage

// File: rtl/readout_byte_mux.sv
// Selects frame data byte idx_i from the snapshot: correlator 0 first, MSB first within each.
module readout_byte_mux
  import correlator_pkg::*;
#(
  parameter int unsigned NUM_CORRELATORS = 66,
  parameter int unsigned RESOLUTION      = 16,
  parameter int unsigned IdxW            = 8
) (
  input  logic [NUM_CORRELATORS*RESOLUTION-1:0] shadow_i,
  input  logic [IdxW-1:0]                       idx_i,
  output logic [7:0]                            byte_o
);

  localparam int unsigned NumBytes     = BYTES_PER_FRAME(NUM_CORRELATORS, RESOLUTION);
  localparam int unsigned BytesPerCorr = RESOLUTION / 8;

  always_comb begin
    byte_o = '0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      // Reverse byte order inside each correlator word so the MSB goes out first.
      if (idx_i == IdxW'(i)) begin
        byte_o = shadow_i[((i / BytesPerCorr) * BytesPerCorr +
                           (BytesPerCorr - 1 - (i % BytesPerCorr))) * 8 +: 8];
      end
    end
  end

endmodule

// File: rtl/correlator_readout_scheduler.sv
// Integration-window sequencer and framed byte serialiser for the correlator snapshot.
// Define READOUT_CHECKSUM_EN to append an XOR checksum byte to every frame.
module correlator_readout_scheduler
  import correlator_pkg::*;
#(
  parameter int unsigned NUM_INPUTS      = 12,
  parameter int unsigned NUM_CORRELATORS = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
  parameter int unsigned RESOLUTION      = 16,
  parameter logic [7:0]  HEADER_BYTE     = HEADER_BYTE_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  enable,
  input  logic [31:0]                           integration_len,
  input  logic [NUM_CORRELATORS*RESOLUTION-1:0] counts_in,
  output logic                                  counts_clear,
  output logic                                  integration_clk_pulse,
  output logic [7:0]                            tx_data,
  output logic                                  tx_valid,
  input  logic                                  tx_ready,
  output logic                                  busy,
  output logic                                  overrun
);

  localparam int unsigned NumBytes = BYTES_PER_FRAME(NUM_CORRELATORS, RESOLUTION);
  localparam int unsigned IdxW     = $clog2(NumBytes + 1);
  localparam int unsigned CountW   = NUM_CORRELATORS * RESOLUTION;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

  state_e              state_q;
  logic [31:0]         win_cnt_q;
  logic [CountW-1:0]   shadow_q;
  logic [7:0]          seq_q;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic                clear_q;
  logic                pulse_q;
  logic                overrun_q;
  logic [IdxW-1:0]     idx_q;

  logic [31:0]         eff_len;
  logic                wrap;
  logic                xfer;
  logic [IdxW-1:0]     mux_idx;
  logic [7:0]          mux_byte;

  assign eff_len = (integration_len < 32'd2) ? 32'd2 : integration_len;
  // >= keeps the window bounded if integration_len shrinks mid-window.
  assign wrap    = enable && (win_cnt_q >= eff_len - 32'd1);
  assign xfer    = tx_valid_q && tx_ready;
  // Look one byte ahead so the next byte is ready on the accepting edge.
  assign mux_idx = (state_q == StData) ? idx_q + IdxW'(1) : '0;

  readout_byte_mux #(
    .NUM_CORRELATORS(NUM_CORRELATORS),
    .RESOLUTION     (RESOLUTION),
    .IdxW           (IdxW)
  ) u_byte_mux (
    .shadow_i(shadow_q),
    .idx_i   (mux_idx),
    .byte_o  (mux_byte)
  );

`ifdef READOUT_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR of bytes already accepted in this frame.
  always_ff @(posedge clk) begin
    if (!rst_n || state_q == StIdle) begin
      csum_q <= '0;
    end else if (xfer) begin
      csum_q <= csum_q ^ tx_data_q;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      win_cnt_q  <= '0;
      shadow_q   <= '0;
      seq_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      clear_q    <= 1'b0;
      pulse_q    <= 1'b0;
      overrun_q  <= 1'b0;
      idx_q      <= '0;
    end else begin
      clear_q <= 1'b0;
      pulse_q <= 1'b0;

      if (!enable) begin
        win_cnt_q <= '0;
      end else if (wrap) begin
        win_cnt_q <= '0;
        clear_q   <= 1'b1;
        pulse_q   <= 1'b1;
        if (state_q != StIdle) overrun_q <= 1'b1;
      end else begin
        win_cnt_q <= win_cnt_q + 32'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (wrap) begin
            shadow_q <= counts_in;
            state_q  <= StHdr;
          end
        end
        StHdr: begin
          if (!tx_valid_q) begin
            tx_data_q  <= HEADER_BYTE;
            tx_valid_q <= 1'b1;
          end else if (tx_ready) begin
            tx_data_q <= seq_q;
            state_q   <= StSeq;
          end
        end
        StSeq: begin
          if (xfer) begin
            seq_q     <= seq_q + 8'd1;
            tx_data_q <= mux_byte;
            idx_q     <= '0;
            state_q   <= StData;
          end
        end
        StData: begin
          if (xfer) begin
            if (idx_q == LastIdx) begin
`ifdef READOUT_CHECKSUM_EN
              tx_data_q <= csum_q ^ tx_data_q;
              state_q   <= StCsum;
`else
              tx_valid_q <= 1'b0;
              state_q    <= StIdle;
`endif
            end else begin
              idx_q     <= idx_q + IdxW'(1);
              tx_data_q <= mux_byte;
            end
          end
        end
`ifdef READOUT_CHECKSUM_EN
        StCsum: begin
          if (xfer) begin
            tx_valid_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign counts_clear          = clear_q;
  assign integration_clk_pulse = pulse_q;
  assign tx_data               = tx_data_q;
  assign tx_valid              = tx_valid_q;
  assign busy                  = (state_q != StIdle);
  assign overrun               = overrun_q;

endmodule
